// File: rtl/wavegen_seq_core.sv
// wavegen_seq_core: prefetches 128-bit ramp instructions into a small FIFO and
// plays each one out as a linear ramp on an AXI-stream port, with looping and stop/flush.
module wavegen_seq_core #(
    parameter int ADDR_W     = 33,
    parameter int ADDR_STEP  = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              cpu_read_valid,
    output logic [ADDR_W-1:0] cpu_read_addr,
    input  logic [127:0]      cpu_read_data,
    input  logic              cpu_read_ack,
    output logic [DATA_W-1:0] axis_data,
    output logic              axis_valid,
    output logic              axis_last,
    input  logic              axis_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       seg_count
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int INSTR_W = 97;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]          state;
    logic                loop_q;
    logic [ADDR_W-1:0]   start_addr_q;
    logic                fetch_halt;

    logic [INSTR_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;

    logic signed [31:0]  acc;
    logic signed [31:0]  step_q;
    logic [31:0]         remaining;
    logic                end_q;

    logic [INSTR_W-1:0]  head;
    logic [31:0]         head_n;
    logic                head_end;
    logic                run_ok;
    logic                push;
    logic                issue;
    logic                load;
    logic                zero_len;
    logic                beat;
    logic                seg_end;
    logic                seg_is_end;
    logic                prog_done;
    logic                unused_bits;

    // The active segment keeps its FIFO slot until it finishes, so the
    // prefetch depth counts it; pop therefore happens at segment completion.
    assign head       = fifo_mem[rd_ptr];
    assign head_n     = head[95:64];
    assign head_end   = head[96];
    assign run_ok     = (state == ST_RUN) && !stop;
    assign push       = run_ok && cpu_read_valid && cpu_read_ack;
    assign issue      = run_ok && !cpu_read_valid && !fetch_halt &&
                        (fifo_count < CNT_W'(FIFO_DEPTH));
    assign load       = run_ok && !axis_valid && (fifo_count != '0);
    assign zero_len   = (head_n == 32'd0);
    assign beat       = run_ok && axis_valid && axis_ready;
    assign seg_end    = (beat && axis_last) || (load && zero_len);
    assign seg_is_end = load ? head_end : end_q;
    assign prog_done  = seg_end && seg_is_end && !loop_q;

    assign axis_data   = acc[DATA_W-1:0];
    assign busy        = (state != ST_IDLE);
    assign unused_bits = ^{cpu_read_data[127:97], acc};

    // control FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            loop_q       <= 1'b0;
            start_addr_q <= '0;
            done         <= 1'b0;
            seg_count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state        <= ST_RUN;
                        loop_q       <= loop_en;
                        start_addr_q <= start_addr;
                        seg_count    <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_FLUSH;
                    end else begin
                        if (seg_end) seg_count <= seg_count + 16'd1;
                        if (prog_done) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // fetch stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_read_valid <= 1'b0;
            cpu_read_addr  <= '0;
            fetch_halt     <= 1'b0;
        end else if (state == ST_IDLE) begin
            cpu_read_valid <= 1'b0;
            if (start && !stop) begin
                cpu_read_addr <= start_addr;
                fetch_halt    <= 1'b0;
            end
        end else if (!run_ok || prog_done) begin
            cpu_read_valid <= 1'b0;
        end else if (push) begin
            cpu_read_valid <= 1'b0;
            if (cpu_read_data[96] && loop_q) cpu_read_addr <= start_addr_q;
            else cpu_read_addr <= cpu_read_addr + ADDR_W'(ADDR_STEP);
            if (cpu_read_data[96] && !loop_q) fetch_halt <= 1'b1;
        end else if (issue) begin
            cpu_read_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= cpu_read_data[INSTR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (!run_ok || prog_done) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (seg_end) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(seg_end);
        end
    end

    // execute stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            axis_valid <= 1'b0;
            axis_last  <= 1'b0;
            acc        <= '0;
            step_q     <= '0;
            remaining  <= '0;
            end_q      <= 1'b0;
        end else if (!run_ok) begin
            axis_valid <= 1'b0;
            axis_last  <= 1'b0;
        end else if (load) begin
            acc        <= $signed(head[31:0]);
            step_q     <= $signed(head[63:32]);
            remaining  <= head_n;
            end_q      <= head_end;
            axis_valid <= !zero_len;
            axis_last  <= (head_n == 32'd1);
        end else if (beat) begin
            acc       <= acc + step_q;
            remaining <= remaining - 32'd1;
            if (axis_last) begin
                axis_valid <= 1'b0;
                axis_last  <= 1'b0;
            end else begin
                axis_last <= (remaining == 32'd2);
            end
        end
    end

endmodule

// File: tb/tb_wavegen_seq_core.sv
// Directed bench for wavegen_seq_core: instruction-memory responder with
// programmable ack delay, stream/fetch monitor, and one task per scenario.
`timescale 1ns/1ps
module tb_wavegen_seq_core;
    localparam int ADDR_W     = 33;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam logic [ADDR_W-1:0] BASE = 33'h1_0000_0100;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] start_addr;
    logic              cpu_read_valid;
    logic [ADDR_W-1:0] cpu_read_addr;
    logic [127:0]      cpu_read_data;
    logic              cpu_read_ack;
    logic [DATA_W-1:0] axis_data;
    logic              axis_valid;
    logic              axis_last;
    logic              axis_ready;
    logic              busy;
    logic              done;
    logic [15:0]       seg_count;

    int total = 0;
    int bad   = 0;

    logic [127:0]      mem [16];
    int                ack_delay;
    logic              clr_req;
    int                n_beats, n_fetch, n_done, prot_err;
    logic [31:0]       beat_data [256];
    logic              beat_last [256];
    int                beat_cyc  [256];
    logic [ADDR_W-1:0] fetch_addr [256];

    wavegen_seq_core #(
        .ADDR_W(ADDR_W), .ADDR_STEP(16), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .start_addr(start_addr), .cpu_read_valid(cpu_read_valid),
        .cpu_read_addr(cpu_read_addr), .cpu_read_data(cpu_read_data),
        .cpu_read_ack(cpu_read_ack), .axis_data(axis_data), .axis_valid(axis_valid),
        .axis_last(axis_last), .axis_ready(axis_ready), .busy(busy), .done(done),
        .seg_count(seg_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // memory responder: acks after ack_delay waiting cycles
    initial begin
        int wait_cnt;
        logic [ADDR_W-1:0] off;
        wait_cnt = 0;
        cpu_read_ack = 1'b0;
        cpu_read_data = '0;
        forever begin
            @(posedge clk); #1;
            if (cpu_read_valid && wait_cnt >= ack_delay) begin
                off = (cpu_read_addr - BASE) >> 4;
                cpu_read_ack = 1'b1;
                cpu_read_data = mem[off[3:0]];
                wait_cnt = 0;
            end else if (cpu_read_valid) begin
                cpu_read_ack = 1'b0;
                wait_cnt++;
            end else begin
                cpu_read_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // monitor: records beats, fetches, done cycles and stream-hold violations
    initial begin
        int cyc;
        logic prev_hold;
        logic [DATA_W-1:0] prev_data;
        cyc = 0; prev_hold = 1'b0; prev_data = '0;
        n_beats = 0; n_fetch = 0; n_done = 0; prot_err = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_req) begin
                n_beats = 0; n_fetch = 0; n_done = 0; prot_err = 0;
            end
            if (prev_hold && rst && (!axis_valid || axis_data !== prev_data)) prot_err++;
            if (axis_valid && axis_ready && n_beats < 256) begin
                beat_data[n_beats] = axis_data;
                beat_last[n_beats] = axis_last;
                beat_cyc[n_beats]  = cyc;
                n_beats++;
            end
            if (cpu_read_valid && cpu_read_ack && n_fetch < 256) begin
                fetch_addr[n_fetch] = cpu_read_addr;
                n_fetch++;
            end
            if (done) n_done++;
            prev_hold = rst && !stop && axis_valid && !axis_ready;
            prev_data = axis_data;
        end
    end

    function automatic logic [127:0] mk(input logic [31:0] init, input logic [31:0] step,
                                        input logic [31:0] n, input logic e);
        mk = {31'h5A5AA5A5, e, n, step, init};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs;
        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
    endtask

    task automatic pulse_start(input logic lp);
        loop_en = lp; start_addr = BASE; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin tick(1); k++; end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2 rst = 1'b0;
        tick(2);
        total++; if (axis_valid !== 1'b0 || axis_last !== 1'b0) begin bad++;
            $display("FAIL reset_axis: got valid=%b last=%b want 0 0", axis_valid, axis_last); end
        total++; if (axis_data !== '0) begin bad++;
            $display("FAIL reset_data: got %0h want 0", axis_data); end
        total++; if (cpu_read_valid !== 1'b0 || cpu_read_addr !== '0) begin bad++;
            $display("FAIL reset_fetch: got valid=%b addr=%0h want 0 0", cpu_read_valid, cpu_read_addr); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || seg_count !== 16'd0) begin bad++;
            $display("FAIL reset_ctrl: got busy=%b done=%b seg=%0d want 0 0 0", busy, done, seg_count); end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_single;
        mem[0] = mk(32'd0, 32'd1, 32'd4, 1'b1);
        ack_delay = 0; axis_ready = 1'b1;
        clear_logs; pulse_start(1'b0); wait_done(100); tick(2);
        total++; if (n_done !== 1) begin bad++; $display("FAIL single_done: got %0d pulses want 1", n_done); end
        total++; if (n_beats !== 4) begin bad++; $display("FAIL single_beats: got %0d want 4", n_beats); end
        for (int i = 0; i < 4; i++) begin
            total++; if (beat_data[i] !== 32'(i) || beat_last[i] !== (i == 3)) begin bad++;
                $display("FAIL single_beat%0d: got %0d last=%b want %0d last=%b", i, beat_data[i], beat_last[i], i, (i == 3)); end
        end
        total++; if (seg_count !== 16'd1) begin bad++; $display("FAIL single_segcnt: got %0d want 1", seg_count); end
        total++; if (busy !== 1'b0 || n_fetch !== 1) begin bad++;
            $display("FAIL single_idle: got busy=%b fetches=%0d want 0 1", busy, n_fetch); end
    endtask

    task automatic test_delayed_ack;
        int k;
        int exp_d [6] = '{10, 9, 10, 9, 10, 9};
        for (int i = 0; i < 3; i++) mem[i] = mk(32'd10, 32'hFFFF_FFFF, 32'd2, i == 2);
        ack_delay = 5; axis_ready = 1'b0;
        clear_logs; pulse_start(1'b0);
        k = 0;
        while (n_fetch < 3 && k < 200) begin tick(1); k++; end
        total++; if (n_fetch !== 3) begin bad++; $display("FAIL delay_fetches: got %0d want 3", n_fetch); end
        axis_ready = 1'b1;
        wait_done(100); tick(2);
        for (int i = 0; i < 3; i++) begin
            total++; if (fetch_addr[i] !== BASE + ADDR_W'(16 * i)) begin bad++;
                $display("FAIL delay_addr%0d: got %0h want %0h", i, fetch_addr[i], BASE + ADDR_W'(16 * i)); end
        end
        total++; if (n_beats !== 6) begin bad++; $display("FAIL delay_beats: got %0d want 6", n_beats); end
        for (int i = 0; i < 6; i++) begin
            total++; if (beat_data[i] !== 32'(exp_d[i]) || beat_last[i] !== (i % 2 == 1)) begin bad++;
                $display("FAIL delay_beat%0d: got %0d last=%b want %0d last=%b", i, beat_data[i], beat_last[i], exp_d[i], (i % 2 == 1)); end
        end
        for (int i = 1; i < 6; i++) begin
            total++; if (beat_cyc[i] - beat_cyc[i-1] > 2) begin bad++;
                $display("FAIL delay_gap%0d: got spacing %0d want <=2", i, beat_cyc[i] - beat_cyc[i-1]); end
        end
        total++; if (n_done !== 1 || seg_count !== 16'd3 || prot_err !== 0) begin bad++;
            $display("FAIL delay_end: got done=%0d seg=%0d hold_err=%0d want 1 3 0", n_done, seg_count, prot_err); end
    endtask

    task automatic test_fifo_full;
        for (int i = 0; i < 6; i++) mem[i] = mk(32'(100 * i), 32'd1, 32'd1, i == 5);
        ack_delay = 0; axis_ready = 1'b0;
        clear_logs; pulse_start(1'b0); tick(40);
        total++; if (n_fetch !== FIFO_DEPTH) begin bad++; $display("FAIL full_fetches: got %0d want %0d", n_fetch, FIFO_DEPTH); end
        total++; if (axis_valid !== 1'b1 || axis_data !== 32'd0) begin bad++;
            $display("FAIL full_hold: got valid=%b data=%0d want 1 0", axis_valid, axis_data); end
        tick(10);
        total++; if (cpu_read_valid !== 1'b0 || n_fetch !== FIFO_DEPTH) begin bad++;
            $display("FAIL full_stall: got valid=%b fetches=%0d want 0 %0d", cpu_read_valid, n_fetch, FIFO_DEPTH); end
        axis_ready = 1'b1;
        wait_done(100); tick(2);
        total++; if (n_fetch !== 6 || n_beats !== 6) begin bad++;
            $display("FAIL full_resume: got fetches=%0d beats=%0d want 6 6", n_fetch, n_beats); end
        for (int i = 0; i < 6; i++) begin
            total++; if (beat_data[i] !== 32'(100 * i) || beat_last[i] !== 1'b1) begin bad++;
                $display("FAIL full_beat%0d: got %0d last=%b want %0d last=1", i, beat_data[i], beat_last[i], 100 * i); end
        end
        total++; if (n_done !== 1 || seg_count !== 16'd6 || prot_err !== 0) begin bad++;
            $display("FAIL full_end: got done=%0d seg=%0d hold_err=%0d want 1 6 0", n_done, seg_count, prot_err); end
    endtask

    task automatic test_loop_stop;
        int exp_d [6] = '{5, 7, 7, 5, 7, 7};
        logic exp_l [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        mem[0] = mk(32'd5, 32'd2, 32'd2, 1'b0);
        mem[1] = mk(32'd7, 32'd0, 32'd1, 1'b1);
        ack_delay = 0; axis_ready = 1'b1;
        clear_logs; pulse_start(1'b1); tick(40);
        total++; if (n_fetch < 6 || n_beats < 6) begin bad++;
            $display("FAIL loop_progress: got fetches=%0d beats=%0d want >=6 >=6", n_fetch, n_beats); end
        for (int i = 0; i < 6; i++) begin
            total++; if (fetch_addr[i] !== BASE + ADDR_W'(16 * (i % 2))) begin bad++;
                $display("FAIL loop_addr%0d: got %0h want %0h", i, fetch_addr[i], BASE + ADDR_W'(16 * (i % 2))); end
            total++; if (beat_data[i] !== 32'(exp_d[i]) || beat_last[i] !== exp_l[i]) begin bad++;
                $display("FAIL loop_beat%0d: got %0d last=%b want %0d last=%b", i, beat_data[i], beat_last[i], exp_d[i], exp_l[i]); end
        end
        total++; if (n_done !== 0 || busy !== 1'b1) begin bad++;
            $display("FAIL loop_running: got done=%0d busy=%b want 0 1", n_done, busy); end
        axis_ready = 1'b0;
        tick(10);
        total++; if (axis_valid !== 1'b1) begin bad++; $display("FAIL loop_prestop: got valid=%b want 1", axis_valid); end
        pulse_stop;
        total++; if (axis_valid !== 1'b0 || cpu_read_valid !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL loop_stop1: got axis=%b rd=%b busy=%b want 0 0 1", axis_valid, cpu_read_valid, busy); end
        tick(1);
        total++; if (busy !== 1'b0 || n_done !== 0) begin bad++;
            $display("FAIL loop_stop2: got busy=%b done=%0d want 0 0", busy, n_done); end
    endtask

    task automatic test_stop_fetch;
        ack_delay = 1000; axis_ready = 1'b1;
        clear_logs; pulse_start(1'b0); tick(5);
        total++; if (cpu_read_valid !== 1'b1 || cpu_read_addr !== BASE) begin bad++;
            $display("FAIL stopf_pending: got valid=%b addr=%0h want 1 %0h", cpu_read_valid, cpu_read_addr, BASE); end
        pulse_stop;
        total++; if (cpu_read_valid !== 1'b0) begin bad++; $display("FAIL stopf_drop: got %b want 0", cpu_read_valid); end
        tick(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stopf_idle: got busy=%b want 0", busy); end
        mem[0] = mk(32'd3, 32'd4, 32'd2, 1'b1);
        ack_delay = 0;
        clear_logs; pulse_start(1'b0); wait_done(100); tick(2);
        total++; if (n_beats !== 2 || beat_data[0] !== 32'd3 || beat_data[1] !== 32'd7) begin bad++;
            $display("FAIL stopf_rerun: got n=%0d d0=%0d d1=%0d want 2 3 7", n_beats, beat_data[0], beat_data[1]); end
        total++; if (n_fetch !== 1 || n_done !== 1 || seg_count !== 16'd1) begin bad++;
            $display("FAIL stopf_end: got fetch=%0d done=%0d seg=%0d want 1 1 1", n_fetch, n_done, seg_count); end
    endtask

    task automatic test_zero_len;
        int exp_d [4] = '{1, 2, 20, 23};
        mem[0] = mk(32'd1, 32'd1, 32'd2, 1'b0);
        mem[1] = mk(32'd50, 32'd1, 32'd0, 1'b0);
        mem[2] = mk(32'd20, 32'd3, 32'd2, 1'b1);
        ack_delay = 0; axis_ready = 1'b1;
        clear_logs; pulse_start(1'b0); wait_done(100); tick(2);
        total++; if (n_beats !== 4) begin bad++; $display("FAIL zero_beats: got %0d want 4", n_beats); end
        for (int i = 0; i < 4; i++) begin
            total++; if (beat_data[i] !== 32'(exp_d[i]) || beat_last[i] !== (i % 2 == 1)) begin bad++;
                $display("FAIL zero_beat%0d: got %0d last=%b want %0d last=%b", i, beat_data[i], beat_last[i], exp_d[i], (i % 2 == 1)); end
        end
        total++; if (seg_count !== 16'd3 || n_done !== 1) begin bad++;
            $display("FAIL zero_end: got seg=%0d done=%0d want 3 1", seg_count, n_done); end
    endtask

    task automatic test_reset_mid;
        int k;
        mem[0] = mk(32'd9, 32'd1, 32'd0, 1'b0);
        mem[1] = mk(32'd100, 32'd1, 32'd3, 1'b1);
        ack_delay = 0; axis_ready = 1'b0;
        clear_logs; pulse_start(1'b0);
        k = 0;
        while (axis_valid !== 1'b1 && k < 50) begin tick(1); k++; end
        total++; if (axis_valid !== 1'b1 || seg_count !== 16'd1) begin bad++;
            $display("FAIL rmid_pre: got valid=%b seg=%0d want 1 1", axis_valid, seg_count); end
        rst = 1'b0;
        #1;
        total++; if (axis_valid !== 1'b0 || axis_last !== 1'b0 || axis_data !== '0) begin bad++;
            $display("FAIL rmid_axis: got valid=%b last=%b data=%0d want 0 0 0", axis_valid, axis_last, axis_data); end
        total++; if (busy !== 1'b0 || cpu_read_valid !== 1'b0 || seg_count !== 16'd0 || done !== 1'b0) begin bad++;
            $display("FAIL rmid_ctrl: got busy=%b rd=%b seg=%0d done=%b want 0 0 0 0", busy, cpu_read_valid, seg_count, done); end
        tick(1);
        rst = 1'b1;
        tick(2);
        axis_ready = 1'b1;
        clear_logs; pulse_start(1'b0); wait_done(100); tick(2);
        total++; if (n_beats !== 3) begin bad++; $display("FAIL rmid_beats: got %0d want 3", n_beats); end
        for (int i = 0; i < 3; i++) begin
            total++; if (beat_data[i] !== 32'(100 + i) || beat_last[i] !== (i == 2)) begin bad++;
                $display("FAIL rmid_beat%0d: got %0d last=%b want %0d last=%b", i, beat_data[i], beat_last[i], 100 + i, (i == 2)); end
        end
        total++; if (seg_count !== 16'd2 || n_done !== 1 || n_fetch !== 2) begin bad++;
            $display("FAIL rmid_end: got seg=%0d done=%0d fetch=%0d want 2 1 2", seg_count, n_done, n_fetch); end
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; start_addr = BASE;
        axis_ready = 1'b0; ack_delay = 0; clr_req = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset;
        test_single;
        test_delayed_ack;
        test_fifo_full;
        test_loop_stop;
        test_stop_fetch;
        test_zero_len;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
